// File: rtl/rca_accum.sv
// rca_accum: handshaked ripple-carry accumulator that sums len operands and counts carry-outs
module rca_accum #(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic [CNT_W-1:0] out_carry_cnt,
    output logic             out_ovf,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t           state_q, state_d;
    logic [N-1:0]     acc_q, acc_d, sum;
    logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d, remaining_q, remaining_d;
    logic [N:0]       c;
    always_comb begin
        c[0] = 1'b0;
        for (int i = 0; i < N; i++) begin
            sum[i]   = acc_q[i] ^ in_data[i] ^ c[i];
            c[i+1]   = (acc_q[i] & in_data[i]) | (c[i] & (acc_q[i] ^ in_data[i]));
        end
    end
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        carry_cnt_d = carry_cnt_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: if (start) begin
                acc_d       = '0;
                carry_cnt_d = '0;
                remaining_d = len;
                state_d     = (len == '0) ? DONE : ACCUM;
            end
            ACCUM: if (in_valid) begin
                acc_d       = sum;
                carry_cnt_d = carry_cnt_q + CNT_W'(c[N]);
                remaining_d = remaining_q - CNT_W'(1);
                state_d     = (remaining_q == CNT_W'(1)) ? DONE : ACCUM;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            carry_cnt_q <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carry_cnt_q <= carry_cnt_d;
            remaining_q <= remaining_d;
        end
    end
    assign in_ready      = (state_q == ACCUM);
    assign out_valid     = (state_q == DONE);
    assign busy          = (state_q != IDLE);
    assign out_sum       = acc_q;
    assign out_carry_cnt = carry_cnt_q;
    assign out_ovf       = |carry_cnt_q;
endmodule

// File: tb/tb_rca_accum.sv
// tb_rca_accum: directed stimulus with a behavioural sum/carry model checked every cycle
module tb_rca_accum;
    localparam int N = 8;
    localparam int CNT_W = 4;
    logic             clk = 1'b0;
    logic             rst_n;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     out_sum;
    logic [CNT_W-1:0] out_carry_cnt;
    logic             out_ovf;
    logic             busy;
    int total = 0;
    int bad = 0;
    rca_accum #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_carry_cnt(out_carry_cnt), .out_ovf(out_ovf), .busy(busy)
    );
    always #5 clk = ~clk;
    // Model: plain integer running sum; a carry is whatever spills past 2^N
    bit m_collect = 0, m_result = 0;
    int m_left = 0, m_sum = 0, m_cc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_collect <= 0; m_result <= 0; m_left <= 0; m_sum <= 0; m_cc <= 0;
        end else if (m_result) begin
            if (out_ready) m_result <= 0;
        end else if (m_collect) begin
            if (in_valid) begin
                m_sum  <= (m_sum + int'(in_data)) % (1 << N);
                m_cc   <= m_cc + (m_sum + int'(in_data)) / (1 << N);
                m_left <= m_left - 1;
                if (m_left == 1) begin m_collect <= 0; m_result <= 1; end
            end
        end else if (start) begin
            m_sum <= 0; m_cc <= 0; m_left <= int'(len);
            if (len == 0) m_result <= 1; else m_collect <= 1;
        end
    end
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(m_collect));
        chk("out_valid", int'(out_valid), int'(m_result));
        chk("busy", int'(busy), int'(m_collect | m_result));
        if (!rst_n || m_result) begin
            chk("out_sum", int'(out_sum), m_sum);
            chk("out_carry_cnt", int'(out_carry_cnt), m_cc);
            chk("out_ovf", int'(out_ovf), int'(m_cc != 0));
        end
    end
    task automatic tick;
        @(posedge clk); #1;
    endtask
    task automatic do_start(input int l);
        start = 1'b1; len = CNT_W'(l); tick; start = 1'b0;
    endtask
    task automatic beat(input int d, input int gaps);
        in_valid = 1'b0;
        for (int g = 0; g < gaps; g++) begin
            tick;
            chk("gap_in_ready", int'(in_ready), 1);
        end
        in_valid = 1'b1; in_data = N'(d); tick; in_valid = 1'b0;
    endtask
    task automatic take;
        out_ready = 1'b1; tick; out_ready = 1'b0;
    endtask
    task automatic result(input string name, input int s, input int cc);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_sum"}, int'(out_sum), s);
        chk({name, "_cc"}, int'(out_carry_cnt), cc);
        chk({name, "_ovf"}, int'(out_ovf), int'(cc != 0));
        chk({name, "_model"}, m_sum, s);
    endtask
    task automatic all_zero(input string name);
        chk({name, "_vec"}, int'({in_ready, out_valid, out_sum, out_carry_cnt, out_ovf, busy}), 0);
    endtask
    initial begin
        rst_n = 1'b0;
        #23;
        all_zero("reset");
        tick;
        rst_n = 1'b1;
        do_start(2);
        beat(8'hAA, 0);
        beat(8'hCC, 0);
        result("r032", 8'h76, 1);
        take;
        do_start(3);
        beat(8'h01, 0);
        beat(8'h02, 1);
        beat(8'h03, 1);
        result("r033", 8'h06, 0);
        take;
        do_start(0);
        chk("r034_in_ready", int'(in_ready), 0);
        result("r034", 8'h00, 0);
        take;
        do_start(2);
        beat(8'hFF, 0);
        beat(8'hFF, 0);
        for (int i = 0; i < 5; i++) begin
            result("r035_hold", 8'hFE, 1);
            start = (i == 2); len = 4'd3;
            tick;
            start = 1'b0;
        end
        result("r035_end", 8'hFE, 1);
        start = 1'b1; len = 4'd2;
        take;
        start = 1'b0;
        chk("r035_idle", int'(busy), 0);
        tick;
        chk("r035_ignored", int'(busy), 0);
        do_start(15);
        for (int i = 0; i < 15; i++) beat(8'h80, i % 2);
        result("maxlen", 8'h80, 7);
        take;
        do_start(4);
        beat(8'h11, 0);
        beat(8'h22, 0);
        #2 rst_n = 1'b0;
        #1 all_zero("r036_abort");
        tick;
        rst_n = 1'b1;
        tick;
        chk("r036_no_partial", int'(out_valid), 0);
        do_start(1);
        beat(8'h05, 0);
        result("r036", 8'h05, 0);
        take;
        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
